// File: rtl/four_bit_spi_rx.sv
// -----------------------------------------------------------------------------
// four_bit_spi_rx
// Quad-SDIO SPI receiver. Synchronises cs, sclk and sdio[3:0] into the system
// clock domain and assembles the nibbles of each frame MSB-first into a single
// right-aligned word. Serves as the bus monitor and loopback checker for the
// four_bit_spi transmitter.
//
// Ports
//   clock         in   system clock, all logic on posedge
//   reset_n       in   asynchronous active-low reset
//   cs            in   chip select, active low, asynchronous
//   sclk          in   SPI clock, idles high, asynchronous
//   sdio[3:0]     in   data nibble, sdio[3] is the nibble MSB
//   data_out      out  last valid frame, right-aligned, zero-extended
//   nibbles_rcvd  out  nibbles held in data_out (1..MAX_NIBBLES)
//   data_valid    out  one-cycle pulse when data_out/nibbles_rcvd update
//   overflow      out  last valid frame carried more than MAX_NIBBLES nibbles
//   busy          out  high while a frame is being received
// -----------------------------------------------------------------------------
module four_bit_spi_rx #(
    parameter int unsigned MAX_NIBBLES = 16,
    parameter int unsigned SYNC_STAGES = 2,
    localparam int unsigned CntW = $clog2(MAX_NIBBLES + 1)
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       cs,
    input  logic                       sclk,
    input  logic [3:0]                 sdio,
    output logic [4*MAX_NIBBLES-1:0]   data_out,
    output logic [CntW-1:0]            nibbles_rcvd,
    output logic                       data_valid,
    output logic                       overflow,
    output logic                       busy
);

    localparam int unsigned DataW = 4 * MAX_NIBBLES;

    typedef enum logic [1:0] {
        StWaitIdle,
        StIdle,
        StRecv,
        StDone
    } state_e;

    // Synchroniser chains; index SYNC_STAGES-1 is the synchronised output.
    logic [SYNC_STAGES-1:0]       r_cs_sync;
    logic [SYNC_STAGES-1:0]       r_sclk_sync;
    logic [SYNC_STAGES-1:0][3:0]  r_sdio_sync;
    logic                         r_sclk_s_d;
    // Shifts in ones after reset; its top bit marks the point where the cs
    // chain holds a real pin sample rather than its preset value. Without it
    // WAIT_IDLE would accept the preset cs=1 and pick up a frame that was
    // already in progress when reset was released.
    logic [SYNC_STAGES-1:0]       r_primed;

    logic                         w_cs_s;
    logic                         w_sclk_s;
    logic [3:0]                   w_sdio_s;
    logic                         w_sclk_rise;
    logic                         w_primed;

    state_e                       r_state;
    logic [DataW-1:0]             r_shreg;
    logic [CntW-1:0]              r_count;
    logic                         r_ovf_acc;
    logic [DataW-1:0]             r_data_out;
    logic [CntW-1:0]              r_nibbles_rcvd;
    logic                         r_data_valid;
    logic                         r_overflow;
    logic                         r_busy;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cs_sync   <= '1;
            r_sclk_sync <= '1;
            r_sdio_sync <= '0;
            r_sclk_s_d  <= 1'b1;
            r_primed    <= '0;
        end else begin
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs};
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_sdio_sync <= {r_sdio_sync[SYNC_STAGES-2:0], sdio};
            r_sclk_s_d  <= w_sclk_s;
            r_primed    <= {r_primed[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_sdio_s    = r_sdio_sync[SYNC_STAGES-1];
    assign w_primed    = r_primed[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk_s & ~r_sclk_s_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= StWaitIdle;
            r_shreg        <= '0;
            r_count        <= '0;
            r_ovf_acc      <= 1'b0;
            r_data_out     <= '0;
            r_nibbles_rcvd <= '0;
            r_data_valid   <= 1'b0;
            r_overflow     <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            case (r_state)
                StWaitIdle: begin
                    r_busy <= 1'b0;
                    if (w_primed && w_cs_s) begin
                        r_state <= StIdle;
                    end
                end
                StIdle: begin
                    r_busy <= 1'b0;
                    if (!w_cs_s) begin
                        r_shreg   <= '0;
                        r_count   <= '0;
                        r_ovf_acc <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= StRecv;
                    end
                end
                StRecv: begin
                    // cs release wins over a coincident sclk rise.
                    if (w_cs_s) begin
                        r_busy  <= 1'b0;
                        r_state <= StDone;
                    end else if (w_sclk_rise) begin
                        if (r_count < CntW'(MAX_NIBBLES)) begin
                            r_shreg <= {r_shreg[DataW-5:0], w_sdio_s};
                            r_count <= r_count + CntW'(1);
                        end else begin
                            r_ovf_acc <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    // Empty frames leave the previous result untouched.
                    if (r_count != '0) begin
                        r_data_out     <= r_shreg;
                        r_nibbles_rcvd <= r_count;
                        r_overflow     <= r_ovf_acc;
                        r_data_valid   <= 1'b1;
                    end
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= StWaitIdle;
                end
            endcase
        end
    end

    assign data_out     = r_data_out;
    assign nibbles_rcvd = r_nibbles_rcvd;
    assign data_valid   = r_data_valid;
    assign overflow     = r_overflow;
    assign busy         = r_busy;

endmodule

// File: tb/tb_four_bit_spi_rx.sv
// -----------------------------------------------------------------------------
// tb_four_bit_spi_rx
// Self-checking bench for four_bit_spi_rx: a table of directed frames, random
// frames checked against a frame-level reference model, and hand-written
// sequences for data_valid latency and reset in the middle of a frame.
// -----------------------------------------------------------------------------
module tb_four_bit_spi_rx;

    localparam int unsigned MaxNib     = 16;
    localparam int unsigned SyncStages = 2;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        cs;
    logic        sclk;
    logic [3:0]  sdio;
    logic [63:0] data_out;
    logic [4:0]  nibbles_rcvd;
    logic        data_valid;
    logic        overflow;
    logic        busy;

    always #5 clock = ~clock;

    four_bit_spi_rx #(
        .MAX_NIBBLES(MaxNib),
        .SYNC_STAGES(SyncStages)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .cs           (cs),
        .sclk         (sclk),
        .sdio         (sdio),
        .data_out     (data_out),
        .nibbles_rcvd (nibbles_rcvd),
        .data_valid   (data_valid),
        .overflow     (overflow),
        .busy         (busy)
    );

    int errors = 0;
    int checks = 0;

    // Observed per frame.
    int   pulses = 0;
    logic busy_seen = 1'b0;

    always @(negedge clock) begin
        if (data_valid) pulses = pulses + 1;
        if (busy) busy_seen = 1'b1;
    end

    // Reference model: the result held after the last non-empty frame.
    logic [63:0] m_data;
    int          m_n;
    logic        m_ovf;
    logic [3:0]  frame_q[$];

    function automatic int model_frame();
        logic [63:0] d;
        int          keep;
        if (frame_q.size() == 0) return 0;
        keep = (frame_q.size() > MaxNib) ? MaxNib : frame_q.size();
        d = '0;
        for (int i = 0; i < keep; i++) d = (d << 4) | 64'(frame_q[i]);
        m_data = d;
        m_n    = keep;
        m_ovf  = (frame_q.size() > MaxNib);
        return 1;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // All stimulus tasks start and end on a falling clock edge.
    task automatic clock_nibble(input logic [3:0] nib);
        sclk = 1'b0;
        sdio = nib;
        repeat (2) @(negedge clock);
        sclk = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic begin_frame();
        pulses    = 0;
        busy_seen = 1'b0;
        cs        = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic end_frame();
        cs = 1'b1;
        repeat (8) @(negedge clock);
    endtask

    task automatic send_frame();
        begin_frame();
        foreach (frame_q[i]) clock_nibble(frame_q[i]);
        end_frame();
    endtask

    task automatic check_frame(input string nm, input int ep, input logic [63:0] ed,
                               input int en, input logic eo);
        chk({nm, ".pulses"},    64'(pulses), 64'(ep));
        chk({nm, ".data_out"},  data_out, ed);
        chk({nm, ".nibbles"},   64'(nibbles_rcvd), 64'(en));
        chk({nm, ".overflow"},  64'(overflow), 64'(eo));
        chk({nm, ".busy_seen"}, 64'(busy_seen), 64'd1);
        chk({nm, ".busy_end"},  64'(busy), 64'd0);
    endtask

    typedef struct {
        string       name;
        int          n;
        logic [79:0] word;   // nibble i of the frame is word[4*(n-1-i) +: 4]
        int          exp_pulse;
        logic [63:0] exp_data;
        int          exp_n;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int          lat;
        int          n;
        int          ep;
        logic [79:0] w;

        vecs[0] = '{"full16", 16, 80'h0123_4567_89AB_CDEF, 1, 64'h0123_4567_89AB_CDEF, 16, 1'b0};
        vecs[1] = '{"two",    2,  80'hA5,                  1, 64'hA5,                  2,  1'b0};
        vecs[2] = '{"ovf18",  18, {64'hFEDC_BA98_7654_3210, 8'h77},
                    1, 64'hFEDC_BA98_7654_3210, 16, 1'b1};
        vecs[3] = '{"one",    1,  80'h3,                   1, 64'h3,                   1,  1'b0};
        vecs[4] = '{"empty",  0,  80'h0,                   0, 64'h3,                   1,  1'b0};
        vecs[5] = '{"three",  3,  80'hABC,                 1, 64'hABC,                 3,  1'b0};

        reset_n = 1'b0;
        cs      = 1'b1;
        sclk    = 1'b1;
        sdio    = 4'h0;
        repeat (3) @(negedge clock);
        chk("reset.data_out", data_out, 64'h0);
        chk("reset.nibbles",  64'(nibbles_rcvd), 64'd0);
        chk("reset.valid",    64'(data_valid), 64'd0);
        chk("reset.overflow", 64'(overflow), 64'd0);
        chk("reset.busy",     64'(busy), 64'd0);
        reset_n = 1'b1;
        repeat (4) @(negedge clock);

        // Directed table.
        for (int v = 0; v < 6; v++) begin
            frame_q.delete();
            w = vecs[v].word;
            for (int j = 0; j < vecs[v].n; j++) frame_q.push_back(w[4*(vecs[v].n-1-j) +: 4]);
            send_frame();
            check_frame(vecs[v].name, vecs[v].exp_pulse, vecs[v].exp_data,
                        vecs[v].exp_n, vecs[v].exp_ovf);
        end
        m_data = 64'hABC;
        m_n    = 3;
        m_ovf  = 1'b0;

        // data_valid latency from cs rising at the pin.
        begin_frame();
        clock_nibble(4'h6);
        clock_nibble(4'h9);
        cs  = 1'b1;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clock);
            if (data_valid && lat == 0) lat = i;
        end
        chk("latency", 64'(lat), 64'(SyncStages + 2));
        chk("latency.data", data_out, 64'h69);
        chk("latency.pulses", 64'(pulses), 64'd1);
        m_data = 64'h69;
        m_n    = 2;
        m_ovf  = 1'b0;

        // Random frames against the model.
        for (int r = 0; r < 24; r++) begin
            n = $urandom_range(0, 18);
            frame_q.delete();
            for (int j = 0; j < n; j++) frame_q.push_back(4'($urandom));
            ep = model_frame();
            send_frame();
            check_frame($sformatf("rand%0d", r), ep, m_data, m_n, m_ovf);
        end

        // Reset mid-frame: the partial frame and its tail must be ignored.
        begin_frame();
        for (int j = 0; j < 5; j++) clock_nibble(4'($urandom));
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        chk("midreset.data_out", data_out, 64'h0);
        chk("midreset.nibbles",  64'(nibbles_rcvd), 64'd0);
        chk("midreset.overflow", 64'(overflow), 64'd0);
        reset_n   = 1'b1;
        pulses    = 0;
        busy_seen = 1'b0;
        for (int j = 0; j < 3; j++) clock_nibble(4'($urandom));
        end_frame();
        chk("midreset.pulses", 64'(pulses), 64'd0);
        chk("midreset.busy",   64'(busy_seen), 64'd0);
        chk("midreset.hold",   data_out, 64'h0);
        frame_q.delete();
        frame_q.push_back(4'hB);
        frame_q.push_back(4'hE);
        frame_q.push_back(4'hE);
        frame_q.push_back(4'hF);
        send_frame();
        check_frame("beef", 1, 64'hBEEF, 4, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
